// File: rtl/seg7_scan_driver_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : seg7_pkg                                                      |
// | Brief  : Shared 7-segment constants and hex-to-segment decode.        |
// | Rev    : 1.0  initial release                                          |
// +----------------------------------------------------------------------+
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic       ANODE_OFF = 1'b1;

  // Active-low, bit 6 = segment A ... bit 0 = segment G
  localparam logic [6:0] SEG_CODE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return SEG_CODE[nibble];
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_driver_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : seg7_scan_driver_if                                           |
// | Brief  : Control inputs and display outputs of the scan driver.       |
// | Rev    : 1.0  initial release                                          |
// +----------------------------------------------------------------------+
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 8,
  parameter int BRIGHT_W   = 3
);

  logic                    Enable;
  logic [4*NUM_DIGITS-1:0] In;
  logic [NUM_DIGITS-1:0]   DP_In;
  logic                    Blank_Zeros;
  logic [BRIGHT_W-1:0]     Brightness;
  logic [6:0]              Cathodes;
  logic                    DP;
  logic [NUM_DIGITS-1:0]   Anodes;
  logic                    Frame_Start;

  modport master (
    output Enable, In, DP_In, Blank_Zeros, Brightness,
    input  Cathodes, DP, Anodes, Frame_Start
  );

  modport slave (
    input  Enable, In, DP_In, Blank_Zeros, Brightness,
    output Cathodes, DP, Anodes, Frame_Start
  );

endinterface
`default_nettype wire

// File: rtl/seg7_scan_driver_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : seg7_tick_gen                                                 |
// | Brief  : Digit-slot prescaler with wrap pulse and enable hold.        |
// | Rev    : 1.0  initial release                                          |
// +----------------------------------------------------------------------+
module seg7_tick_gen #(
  parameter int SLOT   = 4,
  parameter int SLOT_W = $clog2(SLOT)
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              enable,
  output logic [SLOT_W-1:0]      slot_cnt,
  output logic                   wrap
);

  assign wrap = enable && (slot_cnt == SLOT_W'(SLOT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt <= '0;
    end else if (wrap) begin
      slot_cnt <= '0;
    end else if (enable) begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : seg7_scan_driver                                              |
// | Brief  : Time-multiplexed hex display driver with blanking and PWM.   |
// | Rev    : 1.0  initial release                                          |
// +----------------------------------------------------------------------+
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000,
  parameter int BRIGHT_W   = 3
) (
  input  wire logic          Clock_100MHz,
  input  wire logic          Clear,
  seg7_scan_driver_if.slave  bus
);

  localparam int SLOT   = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int SLOT_W = $clog2(SLOT);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("seg7_scan_driver: NUM_DIGITS must be 1..8");
  end
  if (SLOT < 4) begin : g_bad_slot
    $error("seg7_scan_driver: digit slot shorter than 4 clocks");
  end

  logic [SLOT_W-1:0]       slot_cnt;
  logic                    slot_wrap;
  logic [IDX_W-1:0]        idx;
  logic [BRIGHT_W-1:0]     pwm;
  logic                    frame_evt;

  logic [4*NUM_DIGITS-1:0] snap_val;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic                    snap_blank;
  logic [BRIGHT_W-1:0]     snap_bright;

  logic [IDX_W-1:0]        top_digit;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    show_digit;
  logic [NUM_DIGITS-1:0]   nxt_an;
  logic [6:0]              nxt_seg;
  logic                    nxt_dp;

  seg7_tick_gen #(
    .SLOT   (SLOT),
    .SLOT_W (SLOT_W)
  ) u_tick_gen (
    .clk      (Clock_100MHz),
    .rst      (Clear),
    .enable   (bus.Enable),
    .slot_cnt (slot_cnt),
    .wrap     (slot_wrap)
  );

  // The first enabled cycle at slot 0 of digit 0 opens a frame, both after reset and after a wrap.
  assign frame_evt = bus.Enable && (slot_cnt == '0) && (idx == '0);

  always_ff @(posedge Clock_100MHz) begin
    if (Clear) begin
      idx         <= '0;
      pwm         <= '0;
      snap_val    <= '0;
      snap_dp     <= '0;
      snap_blank  <= 1'b0;
      snap_bright <= '0;
    end else begin
      if (slot_wrap) begin
        idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end
      if (bus.Enable) begin
        pwm <= pwm + 1'b1;
      end
      if (frame_evt) begin
        snap_val    <= bus.In;
        snap_dp     <= bus.DP_In;
        snap_blank  <= bus.Blank_Zeros;
        snap_bright <= bus.Brightness;
      end
    end
  end

  always_comb begin
    top_digit = '0;
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (snap_val[4*k +: 4] != 4'h0) begin
        top_digit = IDX_W'(k);
      end
      if (idx == IDX_W'(k)) begin
        cur_nib = snap_val[4*k +: 4];
        cur_dp  = snap_dp[k];
      end
    end
  end

  assign show_digit = !snap_blank || (idx <= top_digit);

  // Slot 0 is dead-time; a blanked digit with its point requested still lights for the DP.
  always_comb begin
    nxt_an  = {NUM_DIGITS{ANODE_OFF}};
    nxt_seg = SEG_BLANK;
    nxt_dp  = 1'b1;
    if (bus.Enable && (slot_cnt != '0)) begin
      if (show_digit) begin
        nxt_seg = hex_to_seg(cur_nib);
      end
      nxt_dp = ~cur_dp;
      if ((show_digit || cur_dp) && (pwm <= snap_bright)) begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
          if (idx == IDX_W'(k)) begin
            nxt_an[k] = ~ANODE_OFF;
          end
        end
      end
    end
  end

  always_ff @(posedge Clock_100MHz) begin
    if (Clear) begin
      bus.Anodes      <= {NUM_DIGITS{ANODE_OFF}};
      bus.Cathodes    <= SEG_BLANK;
      bus.DP          <= 1'b1;
      bus.Frame_Start <= 1'b0;
    end else begin
      bus.Anodes      <= nxt_an;
      bus.Cathodes    <= nxt_seg;
      bus.DP          <= nxt_dp;
      bus.Frame_Start <= frame_evt;
    end
  end

endmodule
`default_nettype wire
